// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting controller and serial_add_ctrl.
//
// Handshake: the master raises start together with sub/A/B. The slave
// accepts on the rising clock edge where start=1 and ready=1. Nothing is
// queued while ready=0. The operands are latched on the accepting edge and
// may change freely afterwards. done is a one-cycle pulse, and S/Cout/V are
// valid in that cycle. They hold their value until the next done.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             V;

    modport master (
        output start, sub, A, B,
        input  ready, done, S, Cout, V
    );

    modport slave (
        input  start, sub, A, B,
        output ready, done, S, Cout, V
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. A single full adder is reused once per
// clock, LSB first, so an N-bit operation takes N RUN cycles plus one DONE
// cycle. Subtraction is A + ~B + 1: B is inverted on capture and the carry
// flip-flop is preset to 1.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_add_ctrl_if.slave     bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             v_q;
    logic             done_q;
    logic             ready_q;

    logic             fa_p;
    logic             fa_s;
    logic             fa_co;

    // The shared 1-bit full adder built from XOR/AND/OR gates.
    always_comb begin
        fa_p  = op_a[0] ^ op_b[0];
        fa_s  = fa_p ^ carry;
        fa_co = (op_a[0] & op_b[0]) | (fa_p & carry);
    end

    // Sequencer: latch the operands, step one bit per cycle, publish the result on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            res     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_a    <= bus.A;
                        op_b    <= bus.sub ? ~bus.B : bus.B;
                        carry   <= bus.sub;
                        cnt     <= '0;
                        res     <= '0;
                        ready_q <= 1'b0;
                        state   <= RUN;
                    end else begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    // The sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
                    res   <= WIDTH'({fa_s, res} >> 1);
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here, which gives V.
                        s_q     <= WIDTH'({fa_s, res} >> 1);
                        cout_q  <= fa_co;
                        v_q     <= carry ^ fa_co;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.S     = s_q;
    assign bus.Cout  = cout_q;
    assign bus.V     = v_q;
    assign bus.done  = done_q;
    assign bus.ready = ready_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8. The expected values are
// worked out by hand in the comments next to each step.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl_if #(.WIDTH(8)) bus ();

    serial_add_ctrl #(.WIDTH(8), .CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request. n counts edges from the accepting edge up to the
    // first cycle with done=1. rdy_low counts the cycles with ready=0.
    // With hold=0, start drops and the operands are scrambled after acceptance.
    task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                          input bit hold, output int n, output int rdy_low);
        bus.sub   = s;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        n         = 0;
        rdy_low   = 0;
        do begin
            tick();
            n++;
            if (!hold) begin
                bus.start = 1'b0;
                bus.A     = 8'($urandom_range(0, 255));
                bus.B     = 8'($urandom_range(0, 255));
                bus.sub   = 1'($urandom_range(0, 1));
            end
            if (!bus.done && !bus.ready) rdy_low++;
        end while (!bus.done && n < 40);
    endtask

    initial begin
        int n;
        int rl;
        int dones;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        tick();
        tick();

        // Reset state.
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_S",     32'(bus.S),     32'h00);
        check("rst_Cout",  32'(bus.Cout),  32'd0);
        check("rst_V",     32'(bus.V),     32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick();

        // 0x5A + 0x33 = 0x8D. No carry out. 90+51=141 > 127, so V=1.
        run_op(1'b0, 8'h5A, 8'h33, 1'b0, n, rl);
        check("add1_lat",   32'(n),         32'd9);
        check("add1_S",     32'(bus.S),     32'h8D);
        check("add1_Cout",  32'(bus.Cout),  32'd0);
        check("add1_V",     32'(bus.V),     32'd1);
        check("add1_state", 32'(dbg_state), 32'd2);

        // 0xFF + 0x01 wraps to 0x00 with Cout=1, V=0. ready is low for the 8 RUN cycles.
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, n, rl);
        check("add2_lat",    32'(n),         32'd9);
        check("add2_rdylow", 32'(rl),        32'd8);
        check("add2_ready",  32'(bus.ready), 32'd1);
        check("add2_S",      32'(bus.S),     32'h00);
        check("add2_Cout",   32'(bus.Cout),  32'd1);
        check("add2_V",      32'(bus.V),     32'd0);

        // 0x10 - 0x20 = 0xF0 with a borrow, so Cout=0. 16-32=-16 fits, so V=0.
        run_op(1'b1, 8'h10, 8'h20, 1'b0, n, rl);
        check("sub1_S",    32'(bus.S),    32'hF0);
        check("sub1_Cout", 32'(bus.Cout), 32'd0);
        check("sub1_V",    32'(bus.V),    32'd0);

        // 0x80 - 0x01 = 0x7F with no borrow, so Cout=1. -128-1 overflows, so V=1.
        run_op(1'b1, 8'h80, 8'h01, 1'b0, n, rl);
        check("sub2_S",    32'(bus.S),    32'h7F);
        check("sub2_Cout", 32'(bus.Cout), 32'd1);
        check("sub2_V",    32'(bus.V),    32'd1);
        tick();

        // 0x01 + 0x02. A start pulse in RUN cycle 3 must be ignored, so the result stays 0x03.
        bus.sub   = 1'b0;
        bus.A     = 8'h01;
        bus.B     = 8'h02;
        bus.start = 1'b1;
        tick();
        n = 1;
        bus.start = 1'b0;
        tick();
        n++;
        tick();
        n++;
        check("ign_state", 32'(dbg_state), 32'd1);
        bus.start = 1'b1;
        bus.A     = 8'hAA;
        bus.B     = 8'h55;
        tick();
        n++;
        bus.start = 1'b0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check("ign_lat", 32'(n),     32'd9);
        check("ign_S",   32'(bus.S), 32'h03);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ign_hold_S",    32'(bus.S),    32'h03);
            check("ign_hold_done", 32'(bus.done), 32'd0);
        end

        // Back-to-back operation with start held high.
        // 0x01+0x01=0x02 is followed by 0x7F+0x01=0x80, which gives V=1 and Cout=0.
        run_op(1'b0, 8'h01, 8'h01, 1'b1, n, rl);
        check("b2b1_lat", 32'(n),     32'd9);
        check("b2b1_S",   32'(bus.S), 32'h02);
        run_op(1'b0, 8'h7F, 8'h01, 1'b1, n, rl);
        check("b2b2_gap",  32'(n),        32'd9);
        check("b2b2_S",    32'(bus.S),    32'h80);
        check("b2b2_V",    32'(bus.V),    32'd1);
        check("b2b2_Cout", 32'(bus.Cout), 32'd0);
        bus.start = 1'b0;
        tick();
        check("b2b_idle", 32'(dbg_state), 32'd0);

        // A reset pulse in RUN cycle 4 aborts the operation without a done pulse.
        bus.A     = 8'h33;
        bus.B     = 8'h44;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_done",  32'(bus.done),  32'd0);
        check("abort_S",     32'(bus.S),     32'h00);
        check("abort_Cout",  32'(bus.Cout),  32'd0);
        check("abort_V",     32'(bus.V),     32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("abort_nodone", 32'(dones), 32'd0);

        // 0x0F + 0x01 = 0x10 after the abort.
        run_op(1'b0, 8'h0F, 8'h01, 1'b0, n, rl);
        check("post_lat",  32'(n),        32'd9);
        check("post_S",    32'(bus.S),    32'h10);
        check("post_Cout", 32'(bus.Cout), 32'd0);
        check("post_V",    32'(bus.V),    32'd0);
        tick();
        check("post_done_pulse", 32'(bus.done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that performs an N-bit add/subtract by time-multiplexing a single 1-bit full adder (PNU_XOR2/AND2/OR2 gate cell), one bit per clock, LSB first.
- Owns operand shift registers, the carry flip-flop, a bit counter and a start/done handshake.
- Sits between a requesting controller (start/ready) and the result consumer (done/S).
- Area-minimal alternative to a ripple array of full adders.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CW, 4, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only when ready=1.
- sub  in  1  0 = A+B, 1 = A−B; sampled with start.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- ready  out  1  high in IDLE and DONE; a new start is accepted.
- done  out  1  one-cycle pulse; result valid.
- S  out  WIDTH  result; held stable from done until next accepted start.
- Cout  out  1  carry out of MSB (sub: 1 = no borrow); held like S.
- V  out  1  signed overflow = carry-into-MSB XOR Cout; held like S.

Behaviour:
- Reset (rst_n=0 at a rising clk edge):
  - state=IDLE; S=0, Cout=0, V=0, done=0, ready=1.
  - Carry FF, counter and shift registers cleared.
  - Reset mid-operation aborts; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - start=1 → latch opA=A and opB=(sub ? ~B : B); carry FF=sub; cnt=0; clear result shift register → RUN.
- RUN:
  - ready=0; start ignored (no queuing).
  - Each cycle the full adder sees Ain=opA[0], Bin=opB[0], Cin=carry FF.
  - Sum bit shifts into the result register at MSB; result shifts right.
  - opA and opB shift right; carry FF ← full-adder Cout; cnt ← cnt+1.
  - On the cycle with cnt==WIDTH−1:
    - capture carry FF (carry into MSB) into cmsb;
    - go to DONE.
- DONE (exactly one cycle):
  - done=1.
  - S=result register; Cout=carry FF; V=cmsb XOR carry FF.
  - ready=1.
  - start=1 here is accepted: same actions as IDLE → RUN (back-to-back operation).
  - Otherwise → IDLE.
- Latency: start accepted at edge t → done high in cycle t+WIDTH+1 → throughput WIDTH+1 cycles per op.
- S/Cout/V update only on entry to DONE.
  - Held through IDLE and the following RUN until the next DONE.
- Arithmetic is modulo 2^WIDTH. Subtract = A + ~B + 1 (two's complement), so Cout=1 means A≥B unsigned.
- Operand inputs may change freely after the accepting edge; only the latched copies are used.
- start held high continuously → ops run back to back, one done every WIDTH+1 cycles.

Test Plan:
- WIDTH=8, sub=0, A=0x5A, B=0x33 → done exactly 9 cycles after start; S=0x8D, Cout=0, V=1.
- sub=0, A=0xFF, B=0x01 → S=0x00, Cout=1, V=0; ready low for 8 cycles, high on done cycle.
- sub=1, A=0x10, B=0x20 → S=0xF0, Cout=0 (borrow), V=0. Also sub=1, A=0x80, B=0x01 → S=0x7F, Cout=1, V=1.
- Start 0x01+0x02, then pulse start with A=0xAA, B=0x55 during RUN cycle 3 → ignored; S=0x03. S stays 0x03 in IDLE for 5 cycles.
- start held high with alternating operands (0x01+0x01, then 0x7F+0x01) → done pulses 9 cycles apart; S=0x02 then S=0x80, V=1.
- rst_n low for one edge during RUN cycle 4 → next cycle ready=1, done=0, S=0, Cout=0, V=0. No done appears. A subsequent 0x0F+0x01 gives S=0x10.
